// File: rtl/si3000_emu_pkg.sv
// rtl/si3000_emu_pkg.sv - shared types, word layout and register defaults for the Si3000 emulator
package si3000_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRI,
    ST_GAP1,
    ST_SEC,
    ST_GAP2
  } emu_state_t;

  localparam int PRI_LEN       = 16;
  localparam int SEC_RW_BIT    = 13;
  localparam int SEC_ADDR_MSB  = 12;
  localparam int SEC_ADDR_LSB  = 8;
  localparam int SEC_DATA_MSB  = 7;
  localparam int SEC_DATA_LSB  = 0;
  // Read data is driven once the upper byte (RW + addr) has been shifted in.
  localparam int SEC_RD_OFFSET = 8;

  function automatic logic [7:0] reg_default(input int unsigned idx);
    case (idx)
      1:       reg_default = 8'h00;
      2:       reg_default = 8'h00;
      3:       reg_default = 8'h00;
      4:       reg_default = 8'h00;
      5:       reg_default = 8'h00;
      6:       reg_default = 8'h00;
      7:       reg_default = 8'h00;
      default: reg_default = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/si3000_emu_regfile.sv
// rtl/si3000_emu_regfile.sv - codec control registers, sync write, comb read, defaults on reset
module si3000_emu_regfile
  import si3000_emu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
    end else if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
    end else if (wr_en && (32'(wr_addr) < NUM_REGS)) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < NUM_REGS) ? regs[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/si3000_codec_emu.sv
// rtl/si3000_codec_emu.sv - Si3000 mode-0 serial port device model; SI3000_EMU_LOOPBACK_EN echoes DAC words
module si3000_codec_emu
  import si3000_emu_pkg::*;
#(
  parameter int SCLK_HALF    = 1,
  parameter int FRAME_SCLKS  = 128,
  parameter int NUM_REGS     = 8,
  parameter int MCLK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        codec_reset_n,
  input  logic        mclk,
  input  logic        sdi,
  output logic        sclk,
  output logic        fsync_n,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [15:0] adc_sample,
  output logic        adc_ready,
  output logic [15:0] dac_sample,
  output logic        dac_valid,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data
);

  localparam int SW = $clog2(FRAME_SCLKS);
  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int TW = $clog2(MCLK_TIMEOUT + 1);

  localparam logic [SW-1:0] SLOT_LAST     = SW'(FRAME_SCLKS - 1);
  localparam logic [SW-1:0] SLOT_PRI_END  = SW'(PRI_LEN);
  localparam logic [SW-1:0] SLOT_PRI_LAST = SW'(PRI_LEN - 1);
  localparam logic [SW-1:0] SLOT_SEC      = SW'(FRAME_SCLKS / 2);
  localparam logic [SW-1:0] SLOT_SEC_RD   = SW'(FRAME_SCLKS / 2 + SEC_RD_OFFSET);
  localparam logic [SW-1:0] SLOT_SEC_LAST = SW'(FRAME_SCLKS / 2 + PRI_LEN - 1);
  localparam logic [SW-1:0] SLOT_SEC_END  = SW'(FRAME_SCLKS / 2 + PRI_LEN);
  localparam logic [HW-1:0] HALF_LAST     = HW'(SCLK_HALF - 1);
  localparam logic [TW-1:0] TO_MAX        = TW'(MCLK_TIMEOUT);

  logic [2:0]    mclk_sync;
  logic          mclk_rise;
  logic [TW-1:0] to_cnt;
  logic          mclk_lost;
  logic          hold;
  logic [HW-1:0] half_cnt;
  logic          toggle, rise_stb, fall_stb;
  emu_state_t    state, state_nx;
  logic [SW-1:0] slot, slot_nx;
  logic          shifting, shifting_nx, pri_done, sec_done, reg_wr_en;
  logic [15:0]   tx_sr, rx_word, pri_word;
  logic [14:0]   rx_sr;
  logic [7:0]    rd_data, rd_word;

  // Two sync flops, third stage only for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mclk_sync <= '0;
    else          mclk_sync <= {mclk_sync[1:0], mclk};
  end
  assign mclk_rise = mclk_sync[1] & ~mclk_sync[2];

  // Starts saturated so MCLK counts as absent until the first edge arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                to_cnt <= TO_MAX;
    else if (mclk_rise)          to_cnt <= '0;
    else if (to_cnt != TO_MAX)   to_cnt <= to_cnt + TW'(1);
  end
  assign mclk_lost = (to_cnt == TO_MAX);
  assign hold      = !codec_reset_n || mclk_lost;

  assign toggle   = !hold && mclk_rise && (half_cnt == HALF_LAST);
  assign rise_stb = toggle && !sclk;
  assign fall_stb = toggle && sclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (hold) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (mclk_rise) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        sclk     <= ~sclk;
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      slot  <= '0;
    end else if (hold) begin
      state <= ST_IDLE;
      slot  <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    if (rise_stb) begin
      if (state == ST_IDLE) begin
        state_nx = ST_PRI;
        slot_nx  = '0;
      end else begin
        slot_nx = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        if (slot_nx == '0)                                 state_nx = ST_PRI;
        else if (slot_nx == SLOT_PRI_END)                  state_nx = ST_GAP1;
        else if (slot_nx == SLOT_SEC && dac_sample[0])     state_nx = ST_SEC;
        else if (slot_nx == SLOT_SEC_END && state == ST_SEC) state_nx = ST_GAP2;
      end
    end
  end

  assign shifting    = (state == ST_PRI) || (state == ST_SEC);
  assign shifting_nx = (state_nx == ST_PRI) || (state_nx == ST_SEC);
  assign pri_done    = (state == ST_PRI) && (slot == SLOT_PRI_LAST);
  assign sec_done    = (state == ST_SEC) && (slot == SLOT_SEC_LAST);
  assign rx_word     = {rx_sr, sdi};
  assign reg_wr_en   = fall_stb && sec_done && !rx_word[SEC_RW_BIT];

`ifdef SI3000_EMU_LOOPBACK_EN
  assign pri_word = {dac_sample[15:1], 1'b0};
`else
  assign pri_word = adc_sample;
`endif

  // Upper secondary byte is already in rx_sr[7:0] when the read byte starts.
  assign rd_word = rx_sr[SEC_RW_BIT-SEC_RD_OFFSET] ? rd_data : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsync_n      <= 1'b1;
      sdo          <= 1'b0;
      sdo_oe       <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      adc_ready    <= 1'b0;
      dac_valid    <= 1'b0;
      dac_sample   <= '0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
    end else begin
      adc_ready    <= 1'b0;
      dac_valid    <= 1'b0;
      reg_wr_valid <= 1'b0;
      if (hold) begin
        fsync_n <= 1'b1;
        sdo     <= 1'b0;
        sdo_oe  <= 1'b0;
        tx_sr   <= '0;
        rx_sr   <= '0;
        if (!codec_reset_n) begin
          dac_sample  <= '0;
          reg_wr_addr <= '0;
          reg_wr_data <= '0;
        end
      end else begin
        if (rise_stb) begin
          fsync_n <= !((state_nx == ST_PRI && slot_nx == '0) ||
                       (state_nx == ST_SEC && slot_nx == SLOT_SEC));
          sdo_oe  <= shifting_nx;
          if (state_nx == ST_PRI && slot_nx == '0) begin
            adc_ready <= 1'b1;
            sdo       <= pri_word[15];
            tx_sr     <= {pri_word[14:0], 1'b0};
          end else if (state_nx == ST_SEC && slot_nx == SLOT_SEC) begin
            sdo   <= 1'b0;
            tx_sr <= '0;
          end else if (state_nx == ST_SEC && slot_nx == SLOT_SEC_RD) begin
            sdo   <= rd_word[7];
            tx_sr <= {rd_word[6:0], 9'b0};
          end else if (shifting_nx) begin
            sdo   <= tx_sr[15];
            tx_sr <= {tx_sr[14:0], 1'b0};
          end else begin
            sdo <= 1'b0;
          end
        end
        if (fall_stb && shifting) begin
          rx_sr <= rx_word[14:0];
          if (pri_done) begin
            dac_sample <= rx_word;
            dac_valid  <= 1'b1;
          end
          if (sec_done && !rx_word[SEC_RW_BIT]) begin
            reg_wr_valid <= 1'b1;
            reg_wr_addr  <= rx_word[SEC_ADDR_MSB:SEC_ADDR_LSB];
            reg_wr_data  <= rx_word[SEC_DATA_MSB:SEC_DATA_LSB];
          end
        end
      end
    end
  end

  si3000_emu_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!codec_reset_n),
    .wr_en   (reg_wr_en),
    .wr_addr (rx_word[SEC_ADDR_MSB:SEC_ADDR_LSB]),
    .wr_data (rx_word[SEC_DATA_MSB:SEC_DATA_LSB]),
    .rd_addr (rx_sr[SEC_ADDR_MSB-SEC_RD_OFFSET:SEC_ADDR_LSB-SEC_RD_OFFSET]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_si3000_codec_emu.sv
// tb/tb_si3000_codec_emu.sv - frame-level controller model driving and checking si3000_codec_emu
module tb_si3000_codec_emu;

  localparam int FRAME = 128;
  localparam int HALF  = FRAME / 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        codec_reset_n = 1'b0;
  logic        mclk = 1'b0;
  logic        mclk_en = 1'b0;
  logic        sdi = 1'b0;
  logic [15:0] adc_sample = 16'h0;
  logic        sclk, fsync_n, sdo, sdo_oe, adc_ready, dac_valid, reg_wr_valid;
  logic [15:0] dac_sample;
  logic [4:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;

  si3000_codec_emu #(
    .SCLK_HALF(1), .FRAME_SCLKS(FRAME), .NUM_REGS(8), .MCLK_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .codec_reset_n(codec_reset_n), .mclk(mclk), .sdi(sdi),
    .sclk(sclk), .fsync_n(fsync_n), .sdo(sdo), .sdo_oe(sdo_oe),
    .adc_sample(adc_sample), .adc_ready(adc_ready),
    .dac_sample(dac_sample), .dac_valid(dac_valid),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  always #5 clk = ~clk;
  always begin
    #20;
    if (mclk_en) mclk = ~mclk;
    else         mclk = 1'b0;
  end

  int n_cmp = 0, n_fail = 0;
  int n_adc = 0, n_dac = 0, n_wr = 0;
  logic [4:0] last_wr_addr = 5'h0;
  logic [7:0] last_wr_data = 8'h0;

  always @(negedge clk) begin
    if (adc_ready) n_adc++;
    if (dac_valid) n_dac++;
    if (reg_wr_valid) begin
      n_wr++;
      last_wr_addr = reg_wr_addr;
      last_wr_data = reg_wr_data;
    end
  end

  // Reference model: codec register contents and the last received primary word.
  logic [7:0]  m_regs [32];
  logic [15:0] m_dac;

  logic [FRAME-1:0] got_fs, got_oe;
  logic [15:0]      got_pri, got_sec;
  int               gap_ones;

  typedef struct {
    logic [15:0] adc;
    logic [15:0] pri;
    logic [15:0] sec;
    logic [15:0] exp_sec;
  } vec_t;
  vec_t tab [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    m_dac = 16'h0;
  endtask

  task automatic wait_sclk(input logic lvl);
    int t;
    t = 0;
    while (sclk !== lvl) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sclk_wait: sclk %b required %b", sclk, lvl);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  endtask

  // Acts as the controller for n slots, recording what the codec drove at each sclk rise.
  task automatic run_slots(input logic [15:0] pri, input logic [15:0] sec, input int n);
    got_fs = '1; got_oe = '0; got_pri = '0; got_sec = '0; gap_ones = 0;
    for (int s = 0; s < n; s++) begin
      wait_sclk(1'b0);
      wait_sclk(1'b1);
      got_fs[s] = fsync_n;
      got_oe[s] = sdo_oe;
      if (s < 16)                        got_pri[15-s] = sdo;
      else if (s >= HALF && s < HALF+16) got_sec[15-(s-HALF)] = sdo;
      if (!sdo_oe && sdo) gap_ones++;
      if (s < 16)                        sdi = pri[15-s];
      else if (s >= HALF && s < HALF+16) sdi = sec[15-(s-HALF)];
      else                               sdi = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] adc, input logic [15:0] pri, input logic [15:0] sec,
                       input logic has_exp, input logic [15:0] exp_sec_tab);
    logic        sec_taken, is_wr;
    logic [15:0] exp_pri, exp_sec;
    logic [FRAME-1:0] exp_fs, exp_oe;
    logic [4:0]  addr;
    int          a0, d0, w0;
    adc_sample = adc;
    sec_taken  = pri[0];
    is_wr      = sec_taken && !sec[13];
    addr       = sec[12:8];
`ifdef SI3000_EMU_LOOPBACK_EN
    exp_pri = {m_dac[15:1], 1'b0};
`else
    exp_pri = adc;
`endif
    exp_sec = sec[13] ? {8'h00, (addr < 5'd8) ? m_regs[addr] : 8'h00} : 16'h0000;
    if (has_exp) exp_sec = exp_sec_tab;
    exp_fs = '1;
    exp_fs[0] = 1'b0;
    exp_oe = '0;
    exp_oe[15:0] = 16'hFFFF;
    if (sec_taken) begin
      exp_fs[HALF] = 1'b0;
      exp_oe[HALF +: 16] = 16'hFFFF;
    end
    a0 = n_adc; d0 = n_dac; w0 = n_wr;
    run_slots(pri, sec, FRAME);
    check("pri_sdo_word", got_pri, exp_pri);
    if (sec_taken) check("sec_sdo_word", got_sec, exp_sec);
    check("fsync_pattern", got_fs, exp_fs);
    check("sdo_oe_pattern", got_oe, exp_oe);
    check("sdo_idle_zero", gap_ones, 0);
    check("dac_sample", dac_sample, pri);
    check("dac_valid_count", n_dac - d0, 1);
    check("adc_ready_count", n_adc - a0, 1);
    check("reg_wr_count", n_wr - w0, is_wr ? 1 : 0);
    if (is_wr) begin
      check("reg_wr_addr", last_wr_addr, addr);
      check("reg_wr_data", last_wr_data, sec[7:0]);
      if (addr < 5'd8) m_regs[addr] = sec[7:0];
    end
    m_dac = pri;
  endtask

  initial begin
    tab[0] = '{adc: 16'hA5C3, pri: 16'h1234, sec: 16'h0000, exp_sec: 16'h0000};
    tab[1] = '{adc: 16'h0F0F, pri: 16'h0001, sec: 16'h0355, exp_sec: 16'h0000};
    tab[2] = '{adc: 16'h8001, pri: 16'h0001, sec: 16'h2300, exp_sec: 16'h0055};
    tab[3] = '{adc: 16'hFFFF, pri: 16'h0001, sec: 16'h3400, exp_sec: 16'h0000};
    tab[4] = '{adc: 16'h0000, pri: 16'h0001, sec: 16'h1477, exp_sec: 16'h0000};
    tab[5] = '{adc: 16'h1357, pri: 16'h0001, sec: 16'h3400, exp_sec: 16'h0000};
    tab[6] = '{adc: 16'h2468, pri: 16'h0001, sec: 16'h07AA, exp_sec: 16'h0000};
    tab[7] = '{adc: 16'hC001, pri: 16'hBEEF, sec: 16'h2700, exp_sec: 16'h00AA};
    tab[8] = '{adc: 16'h7E57, pri: 16'h0003, sec: 16'h2300, exp_sec: 16'h0055};

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_fsync_n", fsync_n, 1'b1);
    check("rst_sdo", sdo, 1'b0);
    check("rst_sdo_oe", sdo_oe, 1'b0);
    check("rst_dac_sample", dac_sample, 16'h0);
    check("rst_pulses", {adc_ready, dac_valid, reg_wr_valid}, 3'b000);
    reset_n = 1'b1;
    @(negedge clk);
    codec_reset_n = 1'b1;
    mclk_en = 1'b1;

    for (int i = 0; i < 9; i++) frame(tab[i].adc, tab[i].pri, tab[i].sec, 1'b1, tab[i].exp_sec);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] r_adc, r_pri, r_sec;
      r_adc = 16'($urandom);
      r_pri = 16'($urandom);
      r_sec = {2'b00, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 8'($urandom)};
      frame(r_adc, r_pri, r_sec, 1'b0, 16'h0);
    end

    // Codec reset in the middle of the primary slot.
    frame(16'h1111, 16'h0001, 16'h0355, 1'b0, 16'h0);
    run_slots(16'h8000, 16'h0000, 8);
    codec_reset_n = 1'b0;
    @(negedge clk);
    check("crst_sclk", sclk, 1'b0);
    check("crst_fsync_n", fsync_n, 1'b1);
    check("crst_sdo_oe", sdo_oe, 1'b0);
    check("crst_dac_sample", dac_sample, 16'h0);
    repeat (10) @(negedge clk);
    codec_reset_n = 1'b1;
    model_reset();
    frame(16'h2222, 16'h0001, 16'h2300, 1'b1, 16'h0000);

    // MCLK stops in the primary slot; the frame must restart from slot 0.
    frame(16'h3333, 16'h0001, 16'h07C3, 1'b0, 16'h0);
    run_slots(16'h8000, 16'h0000, 6);
    mclk_en = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_timeout_oe", sdo_oe, 1'b1);
    repeat (40) @(negedge clk);
    check("lost_sclk", sclk, 1'b0);
    check("lost_fsync_n", fsync_n, 1'b1);
    check("lost_sdo_oe", sdo_oe, 1'b0);
    mclk_en = 1'b1;
    frame(16'h4444, 16'h0001, 16'h2700, 1'b1, 16'h00C3);
    frame(16'h5555, 16'h0000, 16'h0000, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/si3000_codec_emu.md
Name: si3000_codec_emu

Overview:
- Synthesizable device-side model of the Si3000 serial port in digital interface mode 0.
- Takes MCLK from the FPGA-side Si3000 controller and generates SCLK and FSYNC_N from it.
- Shifts ADC words out on SDO and captures DAC and control words from SDI.
- Holds a small codec control register file.
- Used for on-chip loopback and bench verification of the controller without a physical codec.

Parameters:
- SCLK_HALF, 1: detected MCLK rising edges per SCLK half-period.
- FRAME_SCLKS, 128: SCLK periods per frame; even, >= 64. Secondary slot starts at FRAME_SCLKS/2.
- NUM_REGS, 8: implemented control registers; 5-bit address space.
- MCLK_TIMEOUT, 64: clk cycles without an MCLK edge before MCLK is declared lost.

Ports:
- clk  in  1  system clock (>= 4x MCLK)
- reset_n  in  1  asynchronous, active-low reset
- codec_reset_n  in  1  Si3000_RESET_N from controller; low = codec held in reset
- mclk  in  1  Si3000_MCLK, asynchronous, 2-FF synchronized internally
- sdi  in  1  Si3000_SDI from controller
- sclk  out  1  serial clock
- fsync_n  out  1  frame sync, active low
- sdo  out  1  serial data to controller
- sdo_oe  out  1  SDO drive enable (high only while shifting)
- adc_sample  in  16  word to transmit in the next primary slot
- adc_ready  out  1  1-clk pulse: adc_sample latched
- dac_sample  out  16  last received primary word
- dac_valid  out  1  1-clk pulse: dac_sample updated
- reg_wr_valid  out  1  1-clk pulse: control register written
- reg_wr_addr  out  5  written address
- reg_wr_data  out  8  written data

Behaviour:
- Reset values: sclk=0, fsync_n=1, sdo=0, sdo_oe=0, all pulses 0, dac_sample=0, register file = package defaults.
- Reset conditions: a reset is reset_n low (async) or codec_reset_n low (synchronous, held).
  - Codec reset mid-frame: abort the frame, go to IDLE, restore register defaults, clear counters.
- SCLK generation:
  - An MCLK rising edge is detected from the synchronizer output.
  - Every SCLK_HALF edges, sclk toggles.
  - Internal rise/fall strobes are one clk wide.
- FSM states: IDLE, PRI, GAP1, SEC, GAP2.
  - IDLE -> PRI on the first sclk rise with codec_reset_n high and MCLK present.
  - slot counter 0..FRAME_SCLKS-1 increments on each sclk rise and wraps at FRAME_SCLKS-1 to 0 (PRI).
  - PRI covers slots 0-15; GAP1 follows.
  - SEC covers slots FRAME_SCLKS/2 to +15, entered only if the LSB of the previous primary DAC word was 1. Otherwise those slots stay in GAP1.
  - GAP2 runs from the end of SEC to the wrap.
- FSYNC_N: low for exactly the SCLK period of slot 0, and of slot FRAME_SCLKS/2 when SEC is taken. Asserted and released on sclk rise.
- SDO drive:
  - sdo changes on sclk rise, MSB first; sdo_oe is high during PRI and SEC slots only.
  - Slot-0 rise: latch adc_sample, pulse adc_ready.
- SDI capture:
  - sdi is sampled on sclk fall.
  - After the 16th PRI fall: dac_sample updated, dac_valid pulses the next clk.
- Secondary word format: bit13 = R/W (1 = read), bits12:8 = addr, bits7:0 = data.
  - SDO bits 15..8 are 0.
  - For a read, addr is complete after the 8th fall, so SDO bits 7..0 = reg[addr] (0 if addr >= NUM_REGS).
  - For a write, SDO bits 7..0 = 0.
  - On write completion (16th fall): reg[addr] <= data, and reg_wr_* pulses even if addr >= NUM_REGS. Out-of-range addresses are not stored.
- MCLK loss: no edge for MCLK_TIMEOUT clk cycles -> IDLE, sclk=0, fsync_n=1, sdo_oe=0. Registers are kept. Restart at slot 0.
- Priority for simultaneous events: reset > MCLK loss > frame events.

Optional Feature:
- Macro: SI3000_EMU_LOOPBACK_EN.
- Defined: the PRI SDO word is the previous frame's dac_sample with LSB forced to 0; adc_sample is ignored, but adc_ready still pulses.
- Undefined: the PRI SDO word is the latched adc_sample.

Decomposition:
- Package si3000_emu_pkg holds:
  - FSM state enum.
  - Secondary-word bit positions (RW=13, ADDR 12:8, DATA 7:0).
  - Register default table (reg1=8'h00, reg2=8'h00, reg3=8'h00, reg4=8'h00, reg5=8'h00, reg6=8'h00, reg7=8'h00 by default; reset value list per address).
  - PRI length 16.
- Sub-module si3000_emu_regfile: NUM_REGS x 8 registers with synchronous write, combinational read, and defaults-on-reset.

Test Plan:
- SCLK timing: codec_reset_n=1, MCLK=clk/4, SCLK_HALF=1 -> sclk period = 2 MCLK. fsync_n low for one SCLK every 128 SCLKs. adc_sample=16'hA5C3 appears MSB first on SDO in slots 0-15; adc_ready pulses once per frame.
- Primary capture: controller sends 16'h1234 -> dac_valid once, dac_sample=16'h1234, no secondary FSYNC.
- Register write: primary 16'h0001 then secondary 16'h0355 -> reg[3]=8'h55; reg_wr_valid with addr 3, data 8'h55; sdo_oe high only in the 32 shifting slots.
- Register read: then primary 16'h0001, secondary 16'h2300 -> SDO secondary word 16'h0055; read of addr 20 returns 16'h0000.
- Reset and timeout:
  - codec_reset_n low at slot 7 -> same-cycle IDLE, sclk=0, reg[3] back to default.
  - Stopping MCLK for 64 clk -> IDLE; restart begins at slot 0.
- Loopback: with SI3000_EMU_LOOPBACK_EN, primary 16'hBEEF -> next frame SDO word 16'hBEEE.
